// File: rtl/recorre_ram_ctrl.sv
// recorre_ram_ctrl: walks a RAM address window [dir_inicio, dir_fin] in STEP
// increments, one read request per advance tick, one-shot or looping.
module recorre_ram_ctrl #(
  parameter int ADDR_W  = 26,
  parameter int STEP    = 2,
  parameter int LOOPS_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  dir_inicio,
  input  logic [ADDR_W-1:0]  dir_fin,
  input  logic               modo_loop,
  input  logic               iniciar,
  input  logic               detener,
  input  logic               pausa,
  input  logic               tick,
  input  logic               mem_ack,
  output logic [ADDR_W-1:0]  DireccionRAM,
  output logic               mem_req,
  output logic               activo,
  output logic               fin,
  output logic [LOOPS_W-1:0] vueltas,
  output logic               perdido,
  output logic               err_cfg
);

  typedef enum logic [1:0] {IDLE, LEER, ESPERA} estado_t;

  // STEP widened by one bit so the sum below can carry past the top address
  localparam logic [ADDR_W:0] STEP_W = (ADDR_W+1)'(STEP);

  estado_t             estado, estado_d;
  logic [ADDR_W-1:0]   dir_ini_q, dir_fin_q;
  logic                loop_q;
  logic [ADDR_W-1:0]   dir_ini_d, dir_fin_d, dir_d;
  logic                loop_d;
  logic                fin_d, perdido_d, err_d, req_d;
  logic [LOOPS_W-1:0]  vueltas_d;
  logic [ADDR_W:0]     siguiente;
  logic                tick_ok;

  assign activo    = (estado != IDLE);
  assign tick_ok   = tick & ~pausa;
  assign siguiente = {1'b0, DireccionRAM} + STEP_W;

  // State and datapath registers; synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado       <= IDLE;
      DireccionRAM <= '0;
      dir_ini_q    <= '0;
      dir_fin_q    <= '0;
      loop_q       <= 1'b0;
      vueltas      <= '0;
      mem_req      <= 1'b0;
      fin          <= 1'b0;
      perdido      <= 1'b0;
      err_cfg      <= 1'b0;
    end else begin
      estado       <= estado_d;
      DireccionRAM <= dir_d;
      dir_ini_q    <= dir_ini_d;
      dir_fin_q    <= dir_fin_d;
      loop_q       <= loop_d;
      vueltas      <= vueltas_d;
      mem_req      <= req_d;
      fin          <= fin_d;
      perdido      <= perdido_d;
      err_cfg      <= err_d;
    end
  end

  // Next state and next register values; priority detener > iniciar > ack/tick
  always_comb begin
    estado_d  = estado;
    dir_d     = DireccionRAM;
    dir_ini_d = dir_ini_q;
    dir_fin_d = dir_fin_q;
    loop_d    = loop_q;
    vueltas_d = vueltas;
    fin_d     = 1'b0;
    perdido_d = perdido;
    err_d     = err_cfg;

    if (detener) begin
      estado_d = IDLE;
    end else if (iniciar) begin
      if (dir_inicio <= dir_fin) begin
        dir_ini_d = dir_inicio;
        dir_fin_d = dir_fin;
        loop_d    = modo_loop;
        dir_d     = dir_inicio;
        vueltas_d = '0;
        perdido_d = 1'b0;
        err_d     = 1'b0;
        estado_d  = LEER;
      end else begin
        err_d    = 1'b1;
        estado_d = IDLE;
      end
    end else begin
      unique case (estado)
        IDLE: ;
        LEER: begin
          // a tick here means the sample period was shorter than the memory latency
          if (tick_ok) perdido_d = 1'b1;
          if (mem_ack) estado_d = ESPERA;
        end
        ESPERA: begin
          if (tick_ok) begin
            if (siguiente <= {1'b0, dir_fin_q}) begin
              dir_d    = siguiente[ADDR_W-1:0];
              estado_d = LEER;
            end else if (loop_q) begin
              dir_d    = dir_ini_q;
              fin_d    = 1'b1;
              if (vueltas != '1) vueltas_d = vueltas + LOOPS_W'(1);
              estado_d = LEER;
            end else begin
              // one-shot end: address stays on the last legal value
              fin_d    = 1'b1;
              estado_d = IDLE;
            end
          end
        end
        default: estado_d = IDLE;
      endcase
    end

    // request is asserted for exactly the cycles spent in LEER
    req_d = (estado_d == LEER);
  end

endmodule

// File: tb/tb_recorre_ram_ctrl.sv
// Self-checking bench for recorre_ram_ctrl: directed scenarios plus random
// stimulus, all compared against a behavioural model of the walker.
module tb_recorre_ram_ctrl;

  localparam int ADDR_W  = 26;
  localparam int STEP    = 2;
  localparam int LOOPS_W = 8;
  localparam longint AMAX = (64'd1 << ADDR_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n, modo_loop, iniciar, detener, pausa, tick, mem_ack;
  logic [ADDR_W-1:0]  dir_inicio, dir_fin, DireccionRAM;
  logic               mem_req, activo, fin, perdido, err_cfg;
  logic [LOOPS_W-1:0] vueltas;

  recorre_ram_ctrl #(.ADDR_W(ADDR_W), .STEP(STEP), .LOOPS_W(LOOPS_W)) dut (
    .clk(clk), .rst_n(rst_n), .dir_inicio(dir_inicio), .dir_fin(dir_fin),
    .modo_loop(modo_loop), .iniciar(iniciar), .detener(detener), .pausa(pausa),
    .tick(tick), .mem_ack(mem_ack), .DireccionRAM(DireccionRAM), .mem_req(mem_req),
    .activo(activo), .fin(fin), .vueltas(vueltas), .perdido(perdido), .err_cfg(err_cfg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // behavioural model: phase 0 = idle, 1 = reading, 2 = waiting for tick
  int     m_phase;
  longint m_addr, m_start, m_end;
  bit     m_loop, m_fin, m_perd, m_err;
  int     m_laps;

  // configuration presented on dir_inicio / dir_fin / modo_loop
  longint cfg_di, cfg_df;
  bit     cfg_loop;

  function automatic void model(input bit r, input bit i, input bit d,
                                input bit p, input bit t, input bit a);
    if (!r) begin
      m_phase = 0; m_addr = 0; m_start = 0; m_end = 0; m_loop = 0;
      m_laps = 0; m_fin = 0; m_perd = 0; m_err = 0;
      return;
    end
    m_fin = 0;
    if (d) m_phase = 0;
    else if (i) begin
      if (cfg_di <= cfg_df) begin
        m_start = cfg_di; m_end = cfg_df; m_loop = cfg_loop; m_addr = cfg_di;
        m_laps = 0; m_perd = 0; m_err = 0; m_phase = 1;
      end else begin
        m_err = 1; m_phase = 0;
      end
    end else if (m_phase == 1) begin
      if (t && !p) m_perd = 1;
      if (a) m_phase = 2;
    end else if (m_phase == 2 && t && !p) begin
      if (m_addr + STEP <= m_end) begin
        m_addr = m_addr + STEP; m_phase = 1;
      end else begin
        m_fin = 1;
        if (m_loop) begin
          m_addr = m_start; m_phase = 1;
          if (m_laps < (1 << LOOPS_W) - 1) m_laps++;
        end else m_phase = 0;
      end
    end
  endfunction

  // drive one cycle of inputs, advance the model, compare after the edge
  task automatic step(input bit r, input bit i, input bit d,
                      input bit p, input bit t, input bit a);
    rst_n = r; iniciar = i; detener = d; pausa = p; tick = t; mem_ack = a;
    dir_inicio = cfg_di[ADDR_W-1:0]; dir_fin = cfg_df[ADDR_W-1:0]; modo_loop = cfg_loop;
    model(r, i, d, p, t, a);
    @(negedge clk);
    chk("addr",    64'(DireccionRAM), 64'(m_addr));
    chk("mem_req", 64'(mem_req),      64'(m_phase == 1));
    chk("activo",  64'(activo),       64'(m_phase != 0));
    chk("fin",     64'(fin),          64'(m_fin));
    chk("vueltas", 64'(vueltas),      64'(m_laps));
    chk("perdido", 64'(perdido),      64'(m_perd));
    chk("err_cfg", 64'(err_cfg),      64'(m_err));
  endtask

  task automatic run_cfg(input longint di, input longint df, input bit lp);
    cfg_di = di; cfg_df = df; cfg_loop = lp;
    step(1, 1, 0, 0, 0, 0);
  endtask

  // ack the pending read, then issue one tick
  task automatic ack_tick();
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1, 0);
  endtask

  int fins;

  initial begin
    cfg_di = 0; cfg_df = 0; cfg_loop = 0;
    rst_n = 0; iniciar = 0; detener = 0; pausa = 0; tick = 0; mem_ack = 0;
    dir_inicio = '0; dir_fin = '0; modo_loop = 0;
    @(negedge clk);
    repeat (3) step(0, 1, 0, 0, 1, 1);
    chk("rst_addr", 64'(DireccionRAM), 0);
    chk("rst_activo", 64'(activo), 0);

    // one-shot 0..6
    run_cfg(0, 6, 0);
    chk("os_first", 64'(DireccionRAM), 0);
    chk("os_req", 64'(mem_req), 1);
    ack_tick(); chk("os_a2", 64'(DireccionRAM), 2);
    ack_tick(); chk("os_a4", 64'(DireccionRAM), 4);
    ack_tick(); chk("os_a6", 64'(DireccionRAM), 6);
    ack_tick();
    chk("os_fin", 64'(fin), 1);
    chk("os_hold", 64'(DireccionRAM), 6);
    chk("os_idle", 64'(activo), 0);
    step(1, 0, 0, 0, 1, 1);
    chk("os_fin_pulse", 64'(fin), 0);

    // loop 0x10..0x14, 6 ticks
    run_cfg(32'h10, 32'h14, 1);
    fins = 0;
    for (int k = 0; k < 6; k++) begin
      ack_tick();
      fins += int'(fin);
    end
    chk("lp_addr", 64'(DireccionRAM), 32'h10);
    chk("lp_laps", 64'(vueltas), 2);
    chk("lp_fins", 64'(fins), 2);

    // wrap at the configured limit and at the top of the address space
    run_cfg(32'h2AE5EDE, 32'h2AE5EE0, 1);
    ack_tick(); chk("lim_end", 64'(DireccionRAM), 32'h2AE5EE0);
    ack_tick(); chk("lim_wrap", 64'(DireccionRAM), 32'h2AE5EDE);
    chk("lim_laps", 64'(vueltas), 1);
    run_cfg(AMAX - 3, AMAX, 1);
    ack_tick(); ack_tick();
    chk("top_wrap", 64'(DireccionRAM), 64'(AMAX - 3));

    // slow ack with a tick while reading
    run_cfg(4, 20, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("slow_req", 64'(mem_req), 1);
    step(1, 0, 0, 0, 0, 1);
    chk("slow_req_low", 64'(mem_req), 0);
    chk("slow_perd", 64'(perdido), 1);
    chk("slow_addr", 64'(DireccionRAM), 4);

    // rejected then accepted configuration
    run_cfg(8, 4, 0);
    chk("cfg_err", 64'(err_cfg), 1);
    chk("cfg_idle", 64'(activo), 0);
    run_cfg(4, 8, 0);
    chk("cfg_ok", 64'(err_cfg), 0);
    chk("cfg_run", 64'(activo), 1);

    // pause freezes, detener beats iniciar, reset mid-run
    step(1, 0, 0, 0, 0, 1);
    repeat (3) step(1, 0, 0, 1, 1, 0);
    chk("pause_addr", 64'(DireccionRAM), 4);
    step(1, 1, 1, 0, 0, 0);
    chk("det_idle", 64'(activo), 0);
    chk("det_fin", 64'(fin), 0);
    run_cfg(0, 40, 1);
    ack_tick();
    step(0, 0, 0, 0, 1, 1);
    chk("rst_mid_addr", 64'(DireccionRAM), 0);
    chk("rst_mid_req", 64'(mem_req), 0);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      bit i, r;
      r = ($urandom_range(0, 499) != 0);
      i = ($urandom_range(0, 29) == 0);
      if (i) begin
        if ($urandom_range(0, 2) == 0) cfg_di = AMAX - longint'($urandom_range(0, 12));
        else cfg_di = longint'($urandom_range(0, 40));
        cfg_df = cfg_di + longint'($urandom_range(0, 12));
        if (cfg_df > AMAX) cfg_df = AMAX;
        if ($urandom_range(0, 7) == 0) cfg_df = cfg_di - 1;
        if (cfg_df < 0) cfg_df = 0;
        cfg_loop = $urandom_range(0, 1);
      end
      step(r, i, $urandom_range(0, 79) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
